// File: rtl/word_serializer_pkg.sv
// Shared types and defaults for the word serializer and the serial detector
// that consumes its bit stream.
package word_serializer_pkg;

  // Default word width; the downstream detector bench uses the same value.
  localparam int unsigned WORD_W = 8;

  // Shifter control states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : word_serializer_pkg

// File: rtl/word_serializer.sv
// Parallel-to-serial converter. It accepts N-bit words over a valid/ready
// handshake and sends them MSB first on x, one bit per clock, with
// x_valid/x_first/x_last framing. A one-word pending buffer lets the next
// word load on the same edge that the last bit leaves, so there is no idle
// slot between back-to-back words.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int N = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         stall,
  output logic         x,
  output logic         x_valid,
  output logic         x_first,
  output logic         x_last,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_sreg;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_pbuf;
  logic          r_pvalid;
  logic          w_load;
  logic          w_shift;
  logic          w_accept;

  // The buffer can take a word whenever it is empty. A reload always empties
  // it, and a reload needs pvalid=1 (so in_ready=0), so a reload and an
  // accept never fall on the same edge.
  assign in_ready = !r_pvalid;
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state == SHIFT) || r_pvalid;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values from before the edge, whatever the
  // statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, load/shift controls and the serial outputs.
  // NOTE: every signal gets a default first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    x            = 1'b0;
    x_valid      = 1'b0;
    x_first      = 1'b0;
    x_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pvalid) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        x       = r_sreg[N-1];
        x_valid = 1'b1;
        x_first = (r_cnt == CNT_MAX);
        x_last  = (r_cnt == '0);
        if (!stall) begin
          if (r_cnt != '0) begin
            w_shift = 1'b1;
          end else if (r_pvalid) begin
            w_load = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shift register and bit counter: load from the buffer, or shift left.
  // NOTE: the datapath registers are reset along with the control state, so
  // a reset leaves no trace of a discarded word on x.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_sreg <= r_pbuf;
      r_cnt  <= CNT_MAX;
    end else if (w_shift) begin
      r_sreg <= {r_sreg[N-2:0], 1'b0};
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  // Pending buffer: filled on an accepted handshake, emptied by a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pbuf   <= '0;
      r_pvalid <= 1'b0;
    end else if (w_load) begin
      r_pvalid <= 1'b0;
    end else if (w_accept) begin
      r_pbuf   <= in_data;
      r_pvalid <= 1'b1;
    end
  end

endmodule : word_serializer
